lockable_reg_bank: RTL and testbench

//  Bank of NUM_REGS DATA_W-bit configuration registers, each with its own sticky write-lock.

---
 rtl/lockable_reg_bank_if.sv | 42 ++++
 rtl/lockable_reg_bank.sv | 123 ++++++++++++
 tb/tb_lockable_reg_bank.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lockable_reg_bank_if.sv
// Bus bundle for lockable_reg_bank: write port, lock request, read port and status returns.
// Debug override signals exist only when DEBUG_OVERRIDE_EN is defined.
interface lockable_reg_bank_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int VIOL_W   = 8
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] lock_set;
    logic                scan;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0] lock_status;
    logic                wr_ack;
    logic                wr_err;
    logic [VIOL_W-1:0]   viol_cnt;
`ifdef DEBUG_OVERRIDE_EN
    logic                debug_mode;
    logic                dbg_used;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, lock_set, scan, rd_addr,
`ifdef DEBUG_OVERRIDE_EN
        output debug_mode,
        input  dbg_used,
`endif
        input  rd_data, lock_status, wr_ack, wr_err, viol_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, lock_set, scan, rd_addr,
`ifdef DEBUG_OVERRIDE_EN
        input  debug_mode,
        output dbg_used,
`endif
        output rd_data, lock_status, wr_ack, wr_err, viol_cnt
    );
endinterface

// File: rtl/lockable_reg_bank.sv
// Bank of configuration registers with sticky per-register write locks, ack/err pulses and a
// saturating violation counter. Optional debug override is compiled in with DEBUG_OVERRIDE_EN.
module lockable_reg_bank #(
    parameter int                 DATA_W    = 32,
    parameter int                 NUM_REGS  = 4,
    parameter int                 ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 VIOL_W    = 8
) (
    input logic                clk,
    input logic                reset,
    lockable_reg_bank_if.slave bus
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;
    logic                r_ack;
    logic                r_err;
    logic [VIOL_W-1:0]   r_viol;

    logic [NUM_REGS-1:0] w_wr_sel;
    logic                w_in_range;
    logic                w_locked;
    logic                w_dbg_bypass;
    logic                w_commit;
    logic                w_reject;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_scan_unused;

    // Scan is deliberately left out of every decision; locks hold in scan mode too.
    assign w_scan_unused = bus.scan;

    always_comb begin
        w_wr_sel = '0;
        w_locked = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.wr_addr == ADDR_W'(i)) begin
                w_wr_sel[i] = 1'b1;
                w_locked    = r_lock[i];
            end
        end
    end

    assign w_in_range = |w_wr_sel;

`ifdef DEBUG_OVERRIDE_EN
    logic r_dbg_used;

    assign w_dbg_bypass = bus.debug_mode & w_in_range & w_locked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbg_used <= 1'b0;
        end else if (bus.wr_en && w_dbg_bypass) begin
            r_dbg_used <= 1'b1;
        end
    end

    assign bus.dbg_used = r_dbg_used;
`else
    assign w_dbg_bypass = 1'b0;
`endif

    // Lock check uses the pre-edge lock value, so a same-cycle lock_set does not block this write.
    assign w_commit = bus.wr_en & w_in_range & (~w_locked | w_dbg_bypass);
    assign w_reject = bus.wr_en & ~w_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_wr_sel[i]) begin
                    r_regs[i] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock <= '0;
        end else begin
            r_lock <= r_lock | bus.lock_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_commit;
            r_err <= w_reject;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_viol <= '0;
        end else if (w_reject && (r_viol != '1)) begin
            r_viol <= r_viol + VIOL_W'(1);
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.lock_status = r_lock;
    assign bus.wr_ack      = r_ack;
    assign bus.wr_err      = r_err;
    assign bus.viol_cnt    = r_viol;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Directed and randomized bench for lockable_reg_bank (NUM_REGS=3 to exercise out-of-range addresses).
module tb_lockable_reg_bank;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int AW = 2;
    localparam int VW = 8;
`ifdef DEBUG_OVERRIDE_EN
    localparam bit DBG_FEATURE = 1'b1;
`else
    localparam bit DBG_FEATURE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lockable_reg_bank_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .VIOL_W(VW)) bus ();

    lockable_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL('0), .VIOL_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_lock;
    int            m_viol;
    logic          m_ack;
    logic          m_err;
    logic          m_dbg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_lock = '0;
        m_viol = 0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        m_dbg  = 1'b0;
    endtask

    task automatic check_rd(input string tag, input int a, input logic [DW-1:0] exp);
        bus.rd_addr = AW'(a);
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    // One clock: drive request, let the edge happen, advance the model, compare all outputs.
    task automatic cycle(input logic we, input int addr, input logic [DW-1:0] data,
                         input logic [NR-1:0] lset, input logic scn, input int rda, input logic dbg);
        bit in_range;
        bit locked;
        bit ok;
        bus.wr_en    = we;
        bus.wr_addr  = AW'(addr);
        bus.wr_data  = data;
        bus.lock_set = lset;
        bus.scan     = scn;
        bus.rd_addr  = AW'(rda);
`ifdef DEBUG_OVERRIDE_EN
        bus.debug_mode = dbg;
`endif
        @(posedge clk);
        in_range = (addr < NR);
        locked   = in_range ? m_lock[addr] : 1'b1;
        ok       = in_range && (!locked || (DBG_FEATURE && dbg));
        m_ack    = we && ok;
        m_err    = we && !ok;
        if (m_ack) begin
            m_regs[addr] = data;
            if (locked) m_dbg = 1'b1;
        end
        if (m_err && m_viol < (2 ** VW) - 1) m_viol++;
        m_lock = m_lock | lset;
        #1;
        check("wr_ack", bus.wr_ack, m_ack);
        check("wr_err", bus.wr_err, m_err);
        check("viol_cnt", bus.viol_cnt, m_viol);
        check("lock_status", bus.lock_status, m_lock);
        check("rd_data", bus.rd_data, (rda < NR) ? m_regs[rda] : '0);
`ifdef DEBUG_OVERRIDE_EN
        check("dbg_used", bus.dbg_used, m_dbg);
`endif
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.lock_set = '0; bus.scan = 1'b0; bus.rd_addr = '0;
`ifdef DEBUG_OVERRIDE_EN
        bus.debug_mode = 1'b0;
`endif
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_ack", bus.wr_ack, 1'b0);
        check("rst_err", bus.wr_err, 1'b0);
        check("rst_viol", bus.viol_cnt, 0);
        check("rst_lock", bus.lock_status, 0);
        for (int i = 0; i < NR; i++) check_rd("rst_rd", i, '0);

        cycle(1, 1, 32'hDEADBEEF, 3'b000, 0, 1, 0);
        check("t1_ack", bus.wr_ack, 1'b1);
        check("t1_rd", bus.rd_data, 32'hDEADBEEF);

        cycle(0, 0, '0, 3'b010, 0, 1, 0);
        cycle(1, 1, 32'h1, 3'b000, 0, 1, 0);
        check("t2_err", bus.wr_err, 1'b1);
        check("t2_rd", bus.rd_data, 32'hDEADBEEF);
        check("t2_viol", bus.viol_cnt, 1);

        cycle(1, 2, 32'h55, 3'b100, 0, 2, 0);
        check("t3_ack", bus.wr_ack, 1'b1);
        check("t3_rd", bus.rd_data, 32'h55);
        check("t3_lock", bus.lock_status, 3'b110);
        cycle(1, 2, 32'h66, 3'b000, 0, 2, 0);
        check("t3_err", bus.wr_err, 1'b1);

        cycle(1, 3, 32'h1234, 3'b000, 0, 3, 0);
        check("t5_err", bus.wr_err, 1'b1);
        check("t5_rd_oor", bus.rd_data, '0);
        check_rd("t5_rd0", 0, '0);

        cycle(1, 1, 32'h2, 3'b000, 1, 1, 0);
        check("t4_scan_err", bus.wr_err, 1'b1);
        check("t4_scan_rd", bus.rd_data, 32'hDEADBEEF);
        for (int i = 0; i < 300; i++) cycle(1, 1, DW'(i), 3'b000, 1, 1, 0);
        check("t4_sat", bus.viol_cnt, 8'hFF);
        cycle(1, 1, 32'h3, 3'b000, 0, 1, 0);
        check("t4_hold", bus.viol_cnt, 8'hFF);

`ifdef DEBUG_OVERRIDE_EN
        cycle(1, 1, 32'h7, 3'b000, 0, 1, 1);
        check("t6_ack", bus.wr_ack, 1'b1);
        check("t6_rd", bus.rd_data, 32'h7);
        check("t6_dbg", bus.dbg_used, 1'b1);
        cycle(1, 3, 32'h8, 3'b000, 0, 3, 1);
        check("t6_oor_err", bus.wr_err, 1'b1);
`endif

        // Reset lands between request setup and the edge: write must be discarded.
        bus.wr_en = 1'b1; bus.wr_addr = AW'(0); bus.wr_data = 32'hCAFE0000;
        bus.lock_set = 3'b111; bus.rd_addr = AW'(1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_lock", bus.lock_status, 0);
        check("mid_async_viol", bus.viol_cnt, 0);
        check("mid_async_rd", bus.rd_data, '0);
        model_reset();
        @(posedge clk);
        #1;
        check("mid_ack", bus.wr_ack, 1'b0);
        check("mid_err", bus.wr_err, 1'b0);
        check("mid_lock", bus.lock_status, 0);
        check_rd("mid_rd0", 0, '0);
        reset = 1'b0;
        cycle(0, 0, '0, 3'b000, 0, 0, 0);
        check("post_ack", bus.wr_ack, 1'b0);
        check("post_err", bus.wr_err, 1'b0);

        for (int blk = 0; blk < 3; blk++) begin
            for (int n = 0; n < 200; n++) begin
                cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), $urandom,
                      ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000,
                      1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            end
            reset = 1'b1;
            model_reset();
            #1;
            check("rand_rst_lock", bus.lock_status, 0);
            @(negedge clk);
            reset = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
